// File: rtl/char_renderer.sv
// char_renderer: text-mode renderer. Once per 8-pixel cell it fetches the tile
// code and colour from char RAM and one glyph row from char ROM, then shifts
// the glyph out as RGB332-expanded pixels with blanks/syncs delayed to match.
module char_renderer #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter logic [12:0] COLOR_BASE = 13'h800
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        pxl_cen,
  input  logic [8:0]  hcnt,
  input  logic [8:0]  vcnt,
  input  logic        hb_in,
  input  logic        vb_in,
  input  logic        hs_in,
  input  logic        vs_in,
  output logic [12:0] chram_addr,
  input  logic [7:0]  chram_q,
  output logic [10:0] chrom_addr,
  input  logic [7:0]  chrom_q,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        hb_out,
  output logic        vb_out,
  output logic        hs_out,
  output logic        vs_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CODE,
    S_ATTR,
    S_GLYPH,
    S_DONE
  } state_t;

  localparam logic [9:0]  H_ACTIVE = 10'(COLS * 8);
  localparam logic [9:0]  V_ACTIVE = 10'(ROWS * 8);
  localparam logic [12:0] COLS_W   = 13'(COLS);

  state_t         state_q, state_d;
  logic [12:0]    idx_q, idx_d;
  logic [2:0]     line_q, line_d;
  logic           inr_q, inr_d;
  logic [12:0]    chram_addr_q, chram_addr_d;
  logic [10:0]    chrom_addr_q, chrom_addr_d;
  logic [7:0]     code_q, code_d;
  logic [7:0]     attr_q, attr_d;
  logic [7:0]     glyph_q, glyph_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     col_q, col_d;
  // Sync delay line, element 0 newest; each element is {hb, vb, hs, vs}.
  logic [7:0][3:0] dly_q, dly_d;
  logic [7:0]     pix_r_q, pix_r_d;
  logic [7:0]     pix_g_q, pix_g_d;
  logic [7:0]     pix_b_q, pix_b_d;
  logic           hb_out_q, hb_out_d;
  logic           vb_out_q, vb_out_d;
  logic           hs_out_q, hs_out_d;
  logic           vs_out_q, vs_out_d;

  logic           phase0;
  logic           phase7;
  logic [12:0]    cell_index;
  logic           in_range;
  logic           blank;

  assign phase0     = (hcnt[2:0] == 3'd0);
  assign phase7     = (hcnt[2:0] == 3'd7);
  assign cell_index = ({8'd0, vcnt[7:3]} * COLS_W) + {7'd0, hcnt[8:3]};
  assign in_range   = ({1'b0, hcnt} < H_ACTIVE) && ({1'b0, vcnt} < V_ACTIVE);
  assign blank      = dly_q[7][3] | dly_q[7][2];

  // Fetch FSM next state: phase 0 restarts the sequence from any state.
  always_comb begin
    state_d = state_q;
    if (pxl_cen) begin
      if (phase0) begin
        state_d = S_CODE;
      end else begin
        case (state_q)
          S_CODE:  state_d = S_ATTR;
          S_ATTR:  state_d = S_GLYPH;
          S_GLYPH: state_d = S_DONE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Fetch FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath next values: memory sequencing, glyph shifter, colour and delays.
  always_comb begin
    idx_d        = idx_q;
    line_d       = line_q;
    inr_d        = inr_q;
    chram_addr_d = chram_addr_q;
    chrom_addr_d = chrom_addr_q;
    code_d       = code_q;
    attr_d       = attr_q;
    glyph_d      = glyph_q;
    shift_d      = shift_q;
    col_d        = col_q;
    dly_d        = dly_q;
    pix_r_d      = pix_r_q;
    pix_g_d      = pix_g_q;
    pix_b_d      = pix_b_q;
    hb_out_d     = hb_out_q;
    vb_out_d     = vb_out_q;
    hs_out_d     = hs_out_q;
    vs_out_d     = vs_out_q;
    if (pxl_cen) begin
      if (phase0) begin
        idx_d        = cell_index;
        line_d       = vcnt[2:0];
        inr_d        = in_range;
        chram_addr_d = cell_index;
      end else begin
        case (state_q)
          S_CODE: begin
            code_d       = chram_q;
            chram_addr_d = COLOR_BASE + idx_q;
          end
          S_ATTR: begin
            attr_d       = chram_q;
            chrom_addr_d = {code_q, line_q};
          end
          S_GLYPH: glyph_d = chrom_q;
          default: ;
        endcase
      end

      if (shift_q[7] && !blank) begin
        pix_r_d = {col_q[7:5], col_q[7:5], col_q[7:6]};
        pix_g_d = {col_q[4:2], col_q[4:2], col_q[4:3]};
        pix_b_d = {4{col_q[1:0]}};
      end else begin
        pix_r_d = '0;
        pix_g_d = '0;
        pix_b_d = '0;
      end

      // The last pixel of a cell leaves on the same tick the next glyph loads.
      if (phase7) begin
        if (state_q == S_DONE && inr_q) begin
          shift_d = glyph_q;
          col_d   = attr_q;
        end else begin
          shift_d = '0;
          col_d   = '0;
        end
      end else begin
        shift_d = {shift_q[6:0], 1'b0};
      end

      dly_d    = {dly_q[6:0], {hb_in, vb_in, hs_in, vs_in}};
      hb_out_d = dly_q[7][3];
      vb_out_d = dly_q[7][2];
      hs_out_d = dly_q[7][1];
      vs_out_d = dly_q[7][0];
    end
  end

  // Datapath registers; blanks reset high so the screen starts dark.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idx_q        <= '0;
      line_q       <= '0;
      inr_q        <= 1'b0;
      chram_addr_q <= '0;
      chrom_addr_q <= '0;
      code_q       <= '0;
      attr_q       <= '0;
      glyph_q      <= '0;
      shift_q      <= '0;
      col_q        <= '0;
      dly_q        <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      hb_out_q     <= 1'b1;
      vb_out_q     <= 1'b1;
      hs_out_q     <= 1'b0;
      vs_out_q     <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      line_q       <= line_d;
      inr_q        <= inr_d;
      chram_addr_q <= chram_addr_d;
      chrom_addr_q <= chrom_addr_d;
      code_q       <= code_d;
      attr_q       <= attr_d;
      glyph_q      <= glyph_d;
      shift_q      <= shift_d;
      col_q        <= col_d;
      dly_q        <= dly_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      hb_out_q     <= hb_out_d;
      vb_out_q     <= vb_out_d;
      hs_out_q     <= hs_out_d;
      vs_out_q     <= vs_out_d;
    end
  end

  assign chram_addr = chram_addr_q;
  assign chrom_addr = chrom_addr_q;
  assign pix_r      = pix_r_q;
  assign pix_g      = pix_g_q;
  assign pix_b      = pix_b_q;
  assign hb_out     = hb_out_q;
  assign vb_out     = vb_out_q;
  assign hs_out     = hs_out_q;
  assign vs_out     = vs_out_q;

endmodule

// File: tb/tb_char_renderer.sv
// Bench for char_renderer: directed scan patterns, a history-based model of the
// rendering rules checked every cycle, and hand-computed literal expectations.
module tb_char_renderer;

  localparam int          COLS = 40;
  localparam int          ROWS = 30;
  localparam logic [12:0] CB   = 13'h800;
  localparam int          HMAX = 8192;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        pxl_cen = 1'b0;
  logic [8:0]  hcnt = '0;
  logic [8:0]  vcnt = '0;
  logic        hb_in = 1'b0;
  logic        vb_in = 1'b0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic [12:0] chram_addr;
  logic [7:0]  chram_q = '0;
  logic [10:0] chrom_addr;
  logic [7:0]  chrom_q = '0;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        hb_out, vb_out, hs_out, vs_out;

  logic [7:0]  chram_mem [8192];
  logic [7:0]  chrom_mem [2048];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  char_renderer #(.COLS(COLS), .ROWS(ROWS), .COLOR_BASE(CB)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .pxl_cen(pxl_cen),
    .hcnt(hcnt), .vcnt(vcnt),
    .hb_in(hb_in), .vb_in(vb_in), .hs_in(hs_in), .vs_in(vs_in),
    .chram_addr(chram_addr), .chram_q(chram_q),
    .chrom_addr(chrom_addr), .chrom_q(chrom_q),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hb_out(hb_out), .vb_out(vb_out), .hs_out(hs_out), .vs_out(vs_out)
  );

  always #5 clk_sys = ~clk_sys;

  // Memories return data within one clk_sys of the address changing.
  always @(negedge clk_sys) begin
    chram_q <= chram_mem[chram_addr];
    chrom_q <= chrom_mem[chrom_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [8:0] th [HMAX];
  logic [8:0] tv [HMAX];
  logic [3:0] ts [HMAX];
  int         ntick = 0;

  logic [7:0]  exp_r, exp_g, exp_b;
  logic [3:0]  exp_sync;
  logic [12:0] exp_cha;
  logic [10:0] exp_cra;

  function automatic logic [12:0] idx_of(input logic [8:0] h, input logic [8:0] v);
    return 13'(int'(v[7:3]) * COLS + int'(h[8:3]));
  endfunction

  function automatic bit ph0(input int j);
    return th[j][2:0] == 3'd0;
  endfunction

  task automatic model_reset();
    ntick    = 0;
    exp_r    = '0;
    exp_g    = '0;
    exp_b    = '0;
    exp_sync = 4'b1100;
    exp_cha  = '0;
    exp_cra  = '0;
  endtask

  // Outputs after tick n, derived from the recorded scan history since reset.
  task automatic model_tick(input int n);
    int p, q, k;
    logic [12:0] i;
    logic [7:0]  g, a;
    bit on;
    exp_sync = (n >= 8) ? ts[n-8] : 4'b0000;

    on = 1'b0;
    a  = '0;
    p  = -1;
    for (int j = n - 1; j >= 0; j--) if (th[j][2:0] == 3'd7) begin p = j; break; end
    if (p >= 0 && (n - p - 1) <= 7) begin
      k = n - p - 1;
      q = -1;
      for (int j = p - 1; j >= 0; j--) if (ph0(j)) begin q = j; break; end
      if (q >= 0 && (p - q) >= 4 && th[q] < 9'(COLS * 8) && tv[q] < 9'(ROWS * 8)) begin
        i = idx_of(th[q], tv[q]);
        g = chrom_mem[{chram_mem[i], tv[q][2:0]}];
        a = chram_mem[13'(i + CB)];
        on = g[7-k];
      end
    end
    if (exp_sync[3] || exp_sync[2]) on = 1'b0;
    exp_r = on ? {a[7:5], a[7:5], a[7:6]} : 8'h00;
    exp_g = on ? {a[4:2], a[4:2], a[4:3]} : 8'h00;
    exp_b = on ? {a[1:0], a[1:0], a[1:0], a[1:0]} : 8'h00;

    q = -1;
    for (int j = n; j >= 0; j--) if (ph0(j)) begin q = j; break; end
    if (q < 0)       exp_cha = '0;
    else if (q == n) exp_cha = idx_of(th[q], tv[q]);
    else             exp_cha = 13'(idx_of(th[q], tv[q]) + CB);

    exp_cra = '0;
    for (int j = n - 2; j >= 0; j--) begin
      if (ph0(j) && !ph0(j + 1) && !ph0(j + 2)) begin
        exp_cra = {chram_mem[idx_of(th[j], tv[j])], tv[j][2:0]};
        break;
      end
    end
  endtask

  // Record each tick, advance the model, then compare every cycle.
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      model_reset();
    end else if (pxl_cen && ntick < HMAX) begin
      th[ntick] = hcnt;
      tv[ntick] = vcnt;
      ts[ntick] = {hb_in, vb_in, hs_in, vs_in};
      model_tick(ntick);
      ntick++;
    end
    #1;
    if (chk_en) begin
      check("pix_r", 32'(pix_r), 32'(exp_r));
      check("pix_g", 32'(pix_g), 32'(exp_g));
      check("pix_b", 32'(pix_b), 32'(exp_b));
      check("syncs", 32'({hb_out, vb_out, hs_out, vs_out}), 32'(exp_sync));
      check("chram_addr", 32'(chram_addr), 32'(exp_cha));
      check("chrom_addr", 32'(chrom_addr), 32'(exp_cra));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_tick(input int h, input int v, input logic hb, input int per);
    @(negedge clk_sys);
    hcnt    = 9'(h);
    vcnt    = 9'(v);
    hb_in   = hb;
    vb_in   = (v >= ROWS * 8);
    hs_in   = hcnt[4];
    vs_in   = vcnt[1];
    pxl_cen = 1'b1;
    @(posedge clk_sys);
    #2;
    for (int i = 1; i < per; i++) begin
      @(negedge clk_sys);
      pxl_cen = 1'b0;
    end
  endtask

  logic [7:0] lit_r [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    lit_r = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8192; i++) chram_mem[i] = 8'hFF;
    for (int i = 0; i < 2048; i++) chrom_mem[i] = 8'hFF;
    chram_mem[0]       = 8'h41;
    chram_mem[13'h800] = 8'hE0;
    chrom_mem[11'h208] = 8'hA0;
    chram_mem[1199]    = 8'h5A;
    chram_mem[13'hCAF] = 8'h1F;
    chrom_mem[11'h2D5] = 8'hC3;

    // Reset with the pixel enable toggling.
    #3 reset_n = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      pxl_cen = ~pxl_cen;
    end
    check("rst_hb", 32'(hb_out), 32'd1);
    check("rst_vb", 32'(vb_out), 32'd1);
    check("rst_pix", 32'({pix_r, pix_g, pix_b}), 32'd0);
    check("rst_cha", 32'(chram_addr), 32'd0);
    check("rst_cra", 32'(chrom_addr), 32'd0);
    @(negedge clk_sys);
    pxl_cen = 1'b0;
    reset_n = 1'b1;

    // Single glyph on line 0 at full pixel rate.
    for (int h = 0; h < 16; h++) begin
      do_tick(h, 0, 1'b0, 1);
      if (h >= 8) begin
        check("s2_r", 32'(pix_r), 32'(lit_r[h-8]));
        check("s2_gb", 32'({pix_g, pix_b}), 32'd0);
      end
    end

    // Last cell of the screen: addressing and colour expansion.
    for (int h = 312; h < 328; h++) begin
      do_tick(h, 237, h >= 320, 1);
      if (h == 312) check("s3_cha_code", 32'(chram_addr), 32'd1199);
      if (h == 313) check("s3_cha_attr", 32'(chram_addr), 32'h0CAF);
      if (h == 314) check("s3_cra", 32'(chrom_addr), 32'h02D5);
      if (h == 320) check("s3_rgb_on", 32'({pix_r, pix_g, pix_b}), 32'h0000FFFF);
      if (h == 322) check("s3_g_off", 32'(pix_g), 32'd0);
    end

    // Out of range on an unblanked line: fetches happen, pixels stay black.
    for (int h = 320; h < 336; h++) begin
      do_tick(h, 0, 1'b0, 1);
      if (h == 320) check("s4_cha_code", 32'(chram_addr), 32'd40);
      if (h == 321) check("s4_cha_attr", 32'(chram_addr), 32'h0828);
      if (h == 322) check("s4_cra", 32'(chrom_addr), 32'h07F8);
      if (h >= 328) check("s4_black", 32'({pix_r, pix_g, pix_b}), 32'd0);
    end

    // Same glyph with the pixel enable every 4th clock.
    for (int h = 0; h < 16; h++) begin
      do_tick(h, 0, 1'b0, 4);
      if (h >= 8) check("s5_r_held", 32'(pix_r), 32'(lit_r[h-8]));
    end

    // hcnt jumps from 3 back to 0: aborted cell is black, restart renders.
    for (int h = 0; h < 4; h++) do_tick(h, 0, 1'b0, 1);
    for (int h = 0; h < 16; h++) begin
      do_tick(h, 0, 1'b0, 1);
      if (h >= 4 && h < 8) check("s6_abort", 32'(pix_r), 32'd0);
      if (h >= 8) check("s6_r", 32'(pix_r), 32'(lit_r[h-8]));
    end

    // Phase 7 reached before the fetch completes loads black.
    do_tick(0, 0, 1'b0, 1);
    do_tick(1, 0, 1'b0, 1);
    do_tick(7, 0, 1'b0, 1);
    for (int h = 8; h < 16; h++) begin
      do_tick(h, 0, 1'b0, 1);
      check("s7_nodone", 32'(pix_r), 32'd0);
    end

    // Horizontal blank forces black and is delayed with the pixels.
    for (int h = 0; h < 24; h++) begin
      do_tick(h, 0, h < 8, 1);
      if (h >= 8 && h < 16) check("s8_blank", 32'({hb_out, pix_r}), 32'h100);
      if (h == 16) check("s8_unblank", 32'({hb_out, pix_r}), 32'h0FF);
    end

    // Reset mid-line, then recovery from the first phase-0 tick.
    for (int h = 0; h < 13; h++) do_tick(h, 8, 1'b0, 1);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("s9_rst_now", 32'({hb_out, vb_out, pix_r, pix_g, pix_b}), 32'h3000000);
    check("s9_rst_cha", 32'(chram_addr), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    for (int h = 13; h < 32; h++) begin
      do_tick(h, 8, 1'b0, 1);
      if (h < 24) check("s9_dark", 32'(pix_r), 32'd0);
      if (h == 24) check("s9_first", 32'({pix_r, pix_b}), 32'hFFFF);
    end

    @(negedge clk_sys);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
